imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
- Boot-time program loader sitting directly upstream of cpu_top.
- Accepts a byte stream over a valid/ready link and packs it big-endian into 32-bit words.
- Writes each word into the instruction memory write port at sequential word addresses.
- Holds the CPU in reset (CPU_RSTn low) until the load completes, replacing hierarchical program preload.

Parameters:
- ADDR_W, 6, instruction memory word-address width (64 words).
- DATA_W, 32, instruction word width; fixed at 4 bytes.
- MAX_WORDS, 2**ADDR_W, load length saturation limit.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle pulse that begins a load.
- WORD_CNT  in  ADDR_W+1  number of words to load; sampled on START.
- RX_VALID  in  1  byte-stream valid.
- RX_DATA  in  8  byte-stream data.
- RX_READY  out  1  loader can accept a byte.
- IMEM_WE  out  1  instruction memory write enable, one cycle per word.
- IMEM_ADDR  out  ADDR_W  word address.
- IMEM_WDATA  out  DATA_W  packed instruction word.
- CPU_RSTn  out  1  active-low reset to cpu_top, registered.
- BUSY  out  1  load in progress.
- DONE  out  1  load complete, CPU running.
- ERR  out  1  checksum failure (feature-dependent).

Behaviour:
- All outputs are registered.
- Reset values: RX_READY=0, IMEM_WE=0, IMEM_ADDR=0, IMEM_WDATA=0, CPU_RSTn=0, BUSY=0, DONE=0, ERR=0.
- States: IDLE, RECV, WRITE, CKSUM (feature only), RUN, FAIL.
- IDLE:
  - CPU_RSTn=0.
  - On START, latch min(WORD_CNT, MAX_WORDS) and clear the word index and byte index.
  - If the latched count is 0: go to RUN (no CKSUM phase).
  - Otherwise: go to RECV with BUSY=1 from the next cycle.
- RECV:
  - RX_READY=1.
  - A byte is accepted only on RX_VALID&&RX_READY.
  - Byte 0 goes to bits [31:24], byte 3 to bits [7:0].
  - Cycles with RX_VALID=0 are stalls: no state change, no byte consumed.
  - The handshake on byte 3 moves to WRITE.
- WRITE:
  - Lasts exactly one cycle, entered the cycle after the byte-3 handshake.
  - IMEM_WE=1, IMEM_ADDR=word index, IMEM_WDATA=packed word, RX_READY=0.
  - Then word index +1.
  - If this was the last word: go to CKSUM (feature) or RUN.
  - Otherwise: return to RECV.
  - Throughput: at most one word per 5 cycles.
- RUN:
  - CPU_RSTn=1, DONE=1, BUSY=0, RX_READY=0.
  - CPU_RSTn rises on the cycle after the final WRITE, so the CPU never sees a partial program.
- START handling:
  - START in RUN or FAIL restarts the load: the next cycle has CPU_RSTn=0, DONE=0, ERR=0, and the state follows the IDLE rules.
  - START while BUSY is ignored.
- Address range: IMEM_ADDR never wraps; word index stops at the latched count, which is at most MAX_WORDS.
- RST mid-operation: immediate return to reset values. Words already written stay in memory; the next START reloads from address 0.
- Bytes offered while not in RECV are not consumed (RX_READY=0).

Optional Feature:
- Macro: IMEM_BOOT_LOADER_CKSUM_EN.
- Defined:
  - A running 8-bit modulo-256 sum of all accepted data bytes is kept.
  - After the last WRITE, CKSUM state asserts RX_READY and accepts one byte.
  - Match: go to RUN.
  - Mismatch: go to FAIL, with ERR=1, CPU_RSTn=0, DONE=0 until START or RST.
- Undefined: no CKSUM or FAIL state; ERR is tied to 0.

Decomposition:
- Package imem_boot_loader_pkg holds:
  - state enum type;
  - BYTES_PER_WORD=4 and BYTE_W=8;
  - checksum width constant.
- Sub-module byte_packer:
  - 2-bit byte counter, 32-bit shift register, word_ready pulse;
  - clear input driven on START and RST.
- The FSM and address counter remain in imem_boot_loader.

Test Plan:
- Continuous RX_VALID, WORD_CNT=3, bytes 20 03 00 80 20 04 00 0F AC 04 00 08 -> IMEM_WE at addr 0/1/2 with 0x20030080/0x2004000F/0xAC040008; CPU_RSTn=1 and DONE=1 the cycle after the last write.
- Same stream with RX_VALID low 2 cycles between every byte -> identical writes, no duplicated or dropped bytes, RX_READY held high through stalls.
- WORD_CNT=0 -> RUN the cycle after START, no IMEM_WE. WORD_CNT=100 -> exactly 64 writes, addr 0..63, no wrap.
- RST pulsed after the 2nd byte of word 1 -> all outputs at reset values immediately; a new START with WORD_CNT=1 writes addr 0.
- START in RUN -> CPU_RSTn=0 and DONE=0 next cycle; reload of 2 words overwrites addr 0/1.
- With IMEM_BOOT_LOADER_CKSUM_EN, words 0x20030080 and 0x2004000F:
  - checksum byte 0xD6 -> DONE=1;
  - checksum byte 0x00 -> ERR=1, CPU_RSTn stays 0.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_boot_loader_pkg
// Shared types and constants for the instruction-memory boot loader.
//   state_t         : loader FSM state encoding (also exported on DBG_STATE)
//   BYTES_PER_WORD  : bytes packed into one instruction word
//   BYTE_W          : width of one stream byte
//   CKSUM_W         : width of the running checksum (optional feature)
// -----------------------------------------------------------------------------
package imem_boot_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int CKSUM_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CKSUM = 3'd3,
    ST_RUN   = 3'd4,
    ST_FAIL  = 3'd5
  } state_t;

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// imem_boot_loader_byte_packer
// Packs accepted stream bytes big-endian into one instruction word: the first
// byte of a word ends up in the top byte lane, the fourth in the bottom lane.
// Ports:
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   i_clear         : synchronous clear of byte index and shift register
//   i_accept        : a byte handshake happened this cycle
//   i_data          : byte being accepted
//   o_word          : shift register contents (full word after the 4th byte)
//   o_byte_idx      : index of the next byte within the current word (0..3)
//   o_word_ready    : one-cycle pulse, high the cycle after the 4th byte
// -----------------------------------------------------------------------------
module imem_boot_loader_byte_packer
  import imem_boot_loader_pkg::*;
(
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_clear,
  input  logic                             i_accept,
  input  logic [BYTE_W-1:0]                i_data,
  output logic [BYTES_PER_WORD*BYTE_W-1:0] o_word,
  output logic [1:0]                       o_byte_idx,
  output logic                             o_word_ready
);

  localparam int WORD_W = BYTES_PER_WORD * BYTE_W;

  logic [WORD_W-1:0] r_shift;
  logic [1:0]        r_byte_idx;
  logic              r_word_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift      <= '0;
      r_byte_idx   <= '0;
      r_word_ready <= 1'b0;
    end else begin
      r_word_ready <= 1'b0;
      if (i_clear) begin
        r_shift    <= '0;
        r_byte_idx <= '0;
      end else if (i_accept) begin
        // Shifting left means earlier bytes migrate toward the MSB lane.
        r_shift    <= {r_shift[WORD_W-BYTE_W-1:0], i_data};
        // 2-bit index wraps 3 -> 0 on its own at the end of a word.
        r_byte_idx <= r_byte_idx + 2'd1;
        if (r_byte_idx == 2'(BYTES_PER_WORD - 1)) begin
          r_word_ready <= 1'b1;
        end
      end
    end
  end

  assign o_word       = r_shift;
  assign o_byte_idx   = r_byte_idx;
  assign o_word_ready = r_word_ready;

endmodule

// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
// Boot-time program loader in front of cpu_top. Receives a byte stream over a
// valid/ready link, packs it big-endian into 32-bit words, writes each word to
// sequential instruction-memory addresses, and keeps the CPU in reset until
// the whole program is in memory.
//
// Handshake: a byte transfers on a rising CLK edge where RX_VALID and
// RX_READY are both high; RX_READY never depends combinationally on RX_VALID,
// and RX_VALID low simply stalls the loader with no byte consumed.
//
// Optional feature (macro IMEM_BOOT_LOADER_CKSUM_EN): after the last word one
// extra byte is accepted and compared against the modulo-256 sum of all data
// bytes; a mismatch parks the loader in FAIL with ERR high and the CPU held in
// reset. Without the macro there is no checksum phase and ERR is tied low.
//
// Ports:
//   CLK, RST        : clock (rising edge), asynchronous active-high reset
//   START           : one-cycle pulse that begins a (re)load
//   WORD_CNT        : words to load, sampled on START, saturated at MAX_WORDS
//   RX_VALID/DATA   : byte stream input
//   RX_READY        : loader can take a byte this cycle
//   IMEM_WE/ADDR/WDATA : instruction memory write port, one cycle per word
//   CPU_RSTn        : active-low CPU reset, high only once loading finished
//   BUSY, DONE, ERR : status
//   DBG_STATE       : current FSM state (state_t encoding)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 2**ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W:0]   WORD_CNT,
  input  logic              RX_VALID,
  input  logic [BYTE_W-1:0] RX_DATA,
  output logic              RX_READY,
  output logic              IMEM_WE,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  output logic [DATA_W-1:0] IMEM_WDATA,
  output logic              CPU_RSTn,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [2:0]        DBG_STATE
);

  localparam logic [ADDR_W:0] LP_MAX_WORDS = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] LP_ONE       = (ADDR_W+1)'(1);

  state_t            r_state;
  state_t            w_next_state;

  logic [ADDR_W:0]   r_word_cnt;
  logic [ADDR_W:0]   r_word_idx;
  logic [ADDR_W:0]   w_cnt_clamped;
  logic [ADDR_W-1:0] r_imem_addr;

  logic              r_rx_ready;
  logic              r_cpu_rstn;
  logic              r_busy;
  logic              r_done;

  logic              w_start_acc;
  logic              w_accept;
  logic              w_last_byte;
  logic              w_last_word;

  logic [DATA_W-1:0] w_word;
  logic [1:0]        w_byte_idx;
  logic              w_word_ready;

`ifdef IMEM_BOOT_LOADER_CKSUM_EN
  logic [CKSUM_W-1:0] r_sum;
  logic               r_err;
  logic               w_ck_accept;
`endif

  // ---------------------------------------------------------------------------
  // Handshake / control decode
  // ---------------------------------------------------------------------------
  // START is honoured only when no load is in flight.
  assign w_start_acc = START && ((r_state == ST_IDLE) || (r_state == ST_RUN) ||
                                 (r_state == ST_FAIL));

  assign w_cnt_clamped = (WORD_CNT > LP_MAX_WORDS) ? LP_MAX_WORDS : WORD_CNT;

  // Data bytes are only taken in RECV; the checksum byte is handled separately
  // so it never reaches the packer.
  assign w_accept    = RX_VALID && r_rx_ready && (r_state == ST_RECV);
  assign w_last_byte = w_accept && (w_byte_idx == 2'(BYTES_PER_WORD - 1));
  assign w_last_word = ((r_word_idx + LP_ONE) == r_word_cnt);

`ifdef IMEM_BOOT_LOADER_CKSUM_EN
  assign w_ck_accept = RX_VALID && r_rx_ready && (r_state == ST_CKSUM);
`endif

  // ---------------------------------------------------------------------------
  // Byte packer
  // ---------------------------------------------------------------------------
  imem_boot_loader_byte_packer u_byte_packer (
    .i_clk        (CLK),
    .i_rst        (RST),
    .i_clear      (w_start_acc),
    .i_accept     (w_accept),
    .i_data       (RX_DATA),
    .o_word       (w_word),
    .o_byte_idx   (w_byte_idx),
    .o_word_ready (w_word_ready)
  );

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
      ST_IDLE, ST_RUN, ST_FAIL: begin
`else
      ST_IDLE, ST_RUN: begin
`endif
        if (START) begin
          w_next_state = (w_cnt_clamped == '0) ? ST_RUN : ST_RECV;
        end
      end
      ST_RECV: begin
        if (w_last_byte) begin
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (w_last_word) begin
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
          w_next_state = ST_CKSUM;
`else
          w_next_state = ST_RUN;
`endif
        end else begin
          w_next_state = ST_RECV;
        end
      end
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
      ST_CKSUM: begin
        if (w_ck_accept) begin
          w_next_state = (RX_DATA == r_sum) ? ST_RUN : ST_FAIL;
        end
      end
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // Outputs are decoded from the next state so they line up with the state
  // register without any combinational path to the ports.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_word_cnt  <= '0;
      r_word_idx  <= '0;
      r_imem_addr <= '0;
      r_rx_ready  <= 1'b0;
      r_cpu_rstn  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state    <= w_next_state;
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
      r_rx_ready <= (w_next_state == ST_RECV) || (w_next_state == ST_CKSUM);
      r_busy     <= (w_next_state == ST_RECV) || (w_next_state == ST_WRITE) ||
                    (w_next_state == ST_CKSUM);
`else
      r_rx_ready <= (w_next_state == ST_RECV);
      r_busy     <= (w_next_state == ST_RECV) || (w_next_state == ST_WRITE);
`endif
      r_done     <= (w_next_state == ST_RUN);
      r_cpu_rstn <= (w_next_state == ST_RUN);

      if (w_start_acc) begin
        r_word_cnt  <= w_cnt_clamped;
        r_word_idx  <= '0;
        r_imem_addr <= '0;
      end else begin
        // Address is captured as the word completes so it is valid in the
        // WRITE cycle; the index advances at the end of that cycle. The index
        // never exceeds the latched count, so the address cannot wrap.
        if (w_last_byte) begin
          r_imem_addr <= r_word_idx[ADDR_W-1:0];
        end
        if (w_word_ready) begin
          r_word_idx <= r_word_idx + LP_ONE;
        end
      end
    end
  end

`ifdef IMEM_BOOT_LOADER_CKSUM_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= (w_next_state == ST_FAIL);
      if (w_start_acc) begin
        r_sum <= '0;
      end else if (w_accept) begin
        r_sum <= r_sum + RX_DATA;
      end
    end
  end

  assign ERR = r_err;
`else
  assign ERR = 1'b0;
`endif

  assign RX_READY   = r_rx_ready;
  assign IMEM_WE    = w_word_ready;   // flop in the packer, high only in WRITE
  assign IMEM_ADDR  = r_imem_addr;
  assign IMEM_WDATA = w_word;         // packer shift register holds the word
  assign CPU_RSTn   = r_cpu_rstn;
  assign BUSY       = r_busy;
  assign DONE       = r_done;
  assign DBG_STATE  = r_state;

endmodule

// File: tb/tb_imem_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_boot_loader
// Drives byte streams into imem_boot_loader and checks every instruction
// memory write against expected (address, word) pairs built from the stream.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_boot_loader;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 32;
  localparam int MAX_WORDS = 64;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   word_cnt;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_rstn;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  imem_boot_loader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .START      (start),
    .WORD_CNT   (word_cnt),
    .RX_VALID   (rx_valid),
    .RX_DATA    (rx_data),
    .RX_READY   (rx_ready),
    .IMEM_WE    (imem_we),
    .IMEM_ADDR  (imem_addr),
    .IMEM_WDATA (imem_wdata),
    .CPU_RSTn   (cpu_rstn),
    .BUSY       (busy),
    .DONE       (done),
    .ERR        (err),
    .DBG_STATE  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [7:0]               tx_q[$];
  bit                       poke_start = 1'b0;
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
  bit                       ck_override = 1'b0;
  logic [7:0]               ck_value = 8'h00;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the next expected one.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                 imem_addr, imem_wdata);
      end else begin
        check("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int n);
    start    = 1'b1;
    word_cnt = (ADDR_W+1)'(n);
    tick();
    start    = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 0);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_cpu_rstn"}, cpu_rstn, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input int stall, input bit chk_ready);
    int guard;
    for (int s = 0; s < stall; s++) begin
      rx_valid = 1'b0;
      if (poke_start && chk_ready && s == 0) begin
        start    = 1'b1;
        word_cnt = (ADDR_W+1)'(7);
      end
      @(negedge clk);
      if (chk_ready) check("ready_in_stall", rx_ready, 1);
      tick();
      if (start) begin
        start      = 1'b0;
        poke_start = 1'b0;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    guard    = 0;
    @(negedge clk);
    while (rx_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (rx_ready !== 1'b1) begin
      check("ready_timeout", rx_ready, 1);
      return;
    end
    tick();
  endtask

  // Full load of n words from tx_q; expected writes come from the byte list.
  task automatic run_load(input int n, input int stall_mode);
    int m;
    int st;
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
    logic [7:0] sum;
    logic [7:0] ckb;
    sum = 8'h00;
`endif
    m = (n > MAX_WORDS) ? MAX_WORDS : n;
    for (int w = 0; w < m; w++)
      exp_q.push_back({ADDR_W'(w), tx_q[4*w], tx_q[4*w+1], tx_q[4*w+2], tx_q[4*w+3]});
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
    for (int i = 0; i < 4*m; i++) sum = sum + tx_q[i];
`endif
    pulse_start(n);
    @(negedge clk);
    if (m == 0) begin
      check("zero_done", done, 1);
      check("zero_cpu_rstn", cpu_rstn, 1);
      check("zero_busy", busy, 0);
      tick();
    end else begin
      check("start_busy", busy, 1);
      check("start_rx_ready", rx_ready, 1);
      check("start_cpu_rstn", cpu_rstn, 0);
      check("start_done", done, 0);
      check("start_err", err, 0);
      tick();
      for (int i = 0; i < 4*m; i++) begin
        st = (stall_mode < 0) ? int'($urandom_range(0, 3)) : stall_mode;
        send_byte(tx_q[i], st, (i == 0) || (i % 4 != 0));
      end
      rx_valid = 1'b0;
      @(negedge clk);
      check("last_write_we", imem_we, 1);
      check("write_cpu_rstn", cpu_rstn, 0);
`ifdef IMEM_BOOT_LOADER_CKSUM_EN
      @(negedge clk);
      check("ck_rx_ready", rx_ready, 1);
      check("ck_busy", busy, 1);
      tick();
      ckb = ck_override ? ck_value : sum;
      send_byte(ckb, 0, 1'b0);
      rx_valid = 1'b0;
      @(negedge clk);
      check("ck_done", done, (ckb == sum) ? 1 : 0);
      check("ck_err", err, (ckb == sum) ? 0 : 1);
      check("ck_cpu_rstn", cpu_rstn, (ckb == sum) ? 1 : 0);
      check("ck_busy_after", busy, 0);
`else
      @(negedge clk);
      check("run_done", done, 1);
      check("run_cpu_rstn", cpu_rstn, 1);
      check("run_busy", busy, 0);
      check("run_err", err, 0);
      check("run_rx_ready", rx_ready, 0);
`endif
      tick();
    end
    check("all_writes_seen", exp_q.size(), 0);
  endtask

  task automatic fill_random(input int nbytes);
    tx_q.delete();
    for (int i = 0; i < nbytes; i++) tx_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    word_cnt = '0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    tick();
    check_reset_vals("idle");

    // Directed stream, continuous valid.
    tx_q = '{8'h20, 8'h03, 8'h00, 8'h80, 8'h20, 8'h04, 8'h00, 8'h0F,
             8'hAC, 8'h04, 8'h00, 8'h08};
    run_load(3, 0);
    // Same stream with two idle cycles before every byte (restart from RUN).
    run_load(3, 2);

    // Zero-length load: straight to RUN, no writes.
    run_load(0, 0);
    repeat (3) tick();

    // Oversized load saturates at 64 words; bytes offered afterwards are refused.
    fill_random(4*MAX_WORDS);
    run_load(100, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("run_refuses_bytes", rx_ready, 0);
      tick();
    end
    rx_valid = 1'b0;

    // Reset after the 2nd byte of word 1.
    fill_random(12);
    exp_q.push_back({ADDR_W'(0), tx_q[0], tx_q[1], tx_q[2], tx_q[3]});
    pulse_start(3);
    tick();
    for (int i = 0; i < 6; i++) send_byte(tx_q[i], 0, (i == 0) || (i % 4 != 0));
    rst = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    check("rst_mid_writes_seen", exp_q.size(), 0);
    rx_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    fill_random(4);
    run_load(1, 1);

    // Restart from RUN: 2 words overwrite addresses 0/1.
    fill_random(8);
    run_load(2, -1);

    // START while busy is ignored.
    fill_random(8);
    poke_start = 1'b1;
    run_load(2, 1);

    // Randomized loads.
    for (int k = 0; k < 6; k++) begin
      int n;
      n = int'($urandom_range(1, 6));
      fill_random(4*n);
      run_load(n, -1);
    end

`ifdef IMEM_BOOT_LOADER_CKSUM_EN
    tx_q = '{8'h20, 8'h03, 8'h00, 8'h80, 8'h20, 8'h04, 8'h00, 8'h0F};
    ck_override = 1'b1;
    ck_value    = 8'hD6;
    run_load(2, 0);
    ck_value    = 8'h00;
    run_load(2, 0);
    repeat (2) tick();
    @(negedge clk);
    check("fail_hold_err", err, 1);
    check("fail_hold_cpu_rstn", cpu_rstn, 0);
    tick();
    ck_override = 1'b0;
    fill_random(4);
    run_load(1, 0);
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
